// File: rtl/seg_serial_drv.sv
// Serial eight-digit seven-segment driver: decodes a 32-bit hex number with point and
// blink masks into a 64-bit frame and shifts it out repeatedly to cascaded shift registers.
module seg_serial_drv #(
   parameter int CLK_DIV   = 2,
   parameter int FRAME_GAP = 16,
   parameter int BLINK_DIV = 25000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] Disp_num,
   input  logic [7:0]  point,
   input  logic [7:0]  LE,
   output logic        seg_clk,
   output logic        seg_sout,
   output logic        seg_pen,
   output logic        seg_clrn,
   output logic        busy,
   output logic        frame_done
);

   localparam int DIV_W   = (CLK_DIV   > 1) ? $clog2(CLK_DIV)   : 1;
   localparam int GAP_W   = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
   localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [DIV_W-1:0]   DIV_MAX   = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0]   DIV_ONE   = DIV_W'(1);
   localparam logic [GAP_W-1:0]   GAP_MAX   = GAP_W'(FRAME_GAP - 1);
   localparam logic [GAP_W-1:0]   GAP_ONE   = GAP_W'(1);
   localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_DIV - 1);
   localparam logic [BLINK_W-1:0] BLINK_ONE = BLINK_W'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t               state_r;
   state_t               state_s;
   logic [GAP_W-1:0]     gap_cnt_r;
   logic [DIV_W-1:0]     div_cnt_r;
   logic [6:0]           bit_cnt_r;
   logic [63:0]          frame_r;
   logic [63:0]          frame_s;
   logic [BLINK_W-1:0]   blink_cnt_r;
   logic                 blink_phase_r;
   logic                 gap_end_s;
   logic                 div_end_s;
   logic                 bit_end_s;
   logic                 seg_clk_r;
   logic                 seg_sout_r;
   logic                 seg_pen_r;
   logic                 seg_clrn_r;
   logic                 busy_r;
   logic                 frame_done_r;

   // Active-low gfedcba pattern for one hex digit
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0:    seg = 7'h40;
         4'h1:    seg = 7'h79;
         4'h2:    seg = 7'h24;
         4'h3:    seg = 7'h30;
         4'h4:    seg = 7'h19;
         4'h5:    seg = 7'h12;
         4'h6:    seg = 7'h02;
         4'h7:    seg = 7'h78;
         4'h8:    seg = 7'h00;
         4'h9:    seg = 7'h10;
         4'hA:    seg = 7'h08;
         4'hB:    seg = 7'h03;
         4'hC:    seg = 7'h46;
         4'hD:    seg = 7'h21;
         4'hE:    seg = 7'h06;
         4'hF:    seg = 7'h0E;
         default: seg = 7'h7F;
      endcase
      return seg;
   endfunction

   // Digit i occupies frame[8i+7:8i], so digit 7 leaves first when shifting MSB first
   function automatic logic [63:0] build_frame(input logic [31:0] num, input logic [7:0] pt,
                                               input logic [7:0] le, input logic phase);
      logic [63:0] f;
      f = 64'h0;
      for (int i = 0; i < 8; i++) begin
         if (le[i] && phase) begin
            f[8*i +: 8] = 8'hFF;
         end else begin
            f[8*i +: 8] = {~pt[i], hex_to_seg(num[4*i +: 4])};
         end
      end
      return f;
   endfunction

   assign frame_s   = build_frame(Disp_num, point, LE, blink_phase_r);
   assign gap_end_s = (gap_cnt_r == GAP_MAX);
   assign div_end_s = (div_cnt_r == DIV_MAX);
   assign bit_end_s = seg_clk_r && div_end_s && (bit_cnt_r == 7'd63);

   // Next-state decode
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (gap_end_s) state_s = LOAD;
            else           state_s = IDLE;
         end
         LOAD:  state_s = SHIFT;
         SHIFT: begin
            if (bit_end_s) state_s = DONE;
            else           state_s = SHIFT;
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State register and status outputs, registered from the next state
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r      <= IDLE;
         busy_r       <= 1'b0;
         frame_done_r <= 1'b0;
         seg_pen_r    <= 1'b0;
         seg_clrn_r   <= 1'b0;
      end else begin
         state_r      <= state_s;
         busy_r       <= (state_s != IDLE);
         frame_done_r <= (state_s == DONE);
         seg_clrn_r   <= 1'b1;
         if (state_s == DONE) seg_pen_r <= 1'b1;
         else                 seg_pen_r <= seg_pen_r;
      end
   end

   // Gap timing, frame load and bit-serial shifting
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gap_cnt_r  <= '0;
         div_cnt_r  <= '0;
         bit_cnt_r  <= 7'd0;
         frame_r    <= 64'h0;
         seg_clk_r  <= 1'b0;
         seg_sout_r <= 1'b1;
      end else begin
         case (state_r)
            IDLE: begin
               if (gap_end_s) gap_cnt_r <= '0;
               else           gap_cnt_r <= gap_cnt_r + GAP_ONE;
               seg_clk_r  <= 1'b0;
               seg_sout_r <= 1'b1;
            end
            LOAD: begin
               gap_cnt_r  <= '0;
               frame_r    <= frame_s;
               seg_sout_r <= frame_s[63];
               seg_clk_r  <= 1'b0;
               div_cnt_r  <= '0;
               bit_cnt_r  <= 7'd0;
            end
            SHIFT: begin
               if (div_end_s) begin
                  div_cnt_r <= '0;
                  if (seg_clk_r) begin
                     // End of the high phase: advance to the next bit
                     seg_clk_r  <= 1'b0;
                     frame_r    <= {frame_r[62:0], 1'b0};
                     bit_cnt_r  <= bit_cnt_r + 7'd1;
                     seg_sout_r <= bit_end_s ? 1'b1 : frame_r[62];
                  end else begin
                     seg_clk_r <= 1'b1;
                  end
               end else begin
                  div_cnt_r <= div_cnt_r + DIV_ONE;
               end
            end
            DONE: begin
               seg_clk_r  <= 1'b0;
               seg_sout_r <= 1'b1;
            end
            default: begin
               gap_cnt_r  <= '0;
               seg_clk_r  <= 1'b0;
               seg_sout_r <= 1'b1;
            end
         endcase
      end
   end

   // Free-running blink phase
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         blink_cnt_r   <= '0;
         blink_phase_r <= 1'b0;
      end else if (blink_cnt_r == BLINK_MAX) begin
         blink_cnt_r   <= '0;
         blink_phase_r <= ~blink_phase_r;
      end else begin
         blink_cnt_r   <= blink_cnt_r + BLINK_ONE;
         blink_phase_r <= blink_phase_r;
      end
   end

   assign seg_clk    = seg_clk_r;
   assign seg_sout   = seg_sout_r;
   assign seg_pen    = seg_pen_r;
   assign seg_clrn   = seg_clrn_r;
   assign busy       = busy_r;
   assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seg_serial_drv.sv
// Self-checking bench for seg_serial_drv: cycle-accurate arithmetic model of the frame
// schedule plus a shift-register capture of every frame.
module tb_seg_serial_drv;

   localparam int CD = 3;
   localparam int FG = 16;
   localparam int BD = 300;
   localparam int SH = 128 * CD;
   localparam int P  = 1 + SH + 1 + FG;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] disp_num;
   logic [7:0]  point;
   logic [7:0]  le;
   logic        seg_clk, seg_sout, seg_pen, seg_clrn, busy, frame_done;

   seg_serial_drv #(.CLK_DIV(CD), .FRAME_GAP(FG), .BLINK_DIV(BD)) dut (
      .clk(clk), .rst(rst), .Disp_num(disp_num), .point(point), .LE(le),
      .seg_clk(seg_clk), .seg_sout(seg_sout), .seg_pen(seg_pen), .seg_clrn(seg_clrn),
      .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   int          c;
   int          r_g;
   int          frame_idx = 0;
   int          cap_n = 0;
   logic [63:0] cap = 64'h0;
   logic [63:0] cur_exp = 64'h0;
   logic        prev_clk = 1'b0;
   logic [6:0]  seg_tab [16];
   logic [63:0] known [4];
   logic [31:0] tab_num [7];
   logic [7:0]  tab_pt [7];
   logic [7:0]  tab_le [7];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [63:0] model_frame(input logic [31:0] num, input logic [7:0] pt,
                                               input logic [7:0] l, input logic ph);
      logic [63:0] f;
      logic [7:0]  b;
      logic [3:0]  nib;
      f = 64'h0;
      for (int d = 7; d >= 0; d--) begin
         nib = 4'((num >> (4 * d)) & 32'hF);
         b = (l[d] && ph) ? 8'hFF : {~pt[d], seg_tab[nib]};
         f = {f[55:0], b};
      end
      return f;
   endfunction

   task automatic step();
      int   k, s;
      logic e_busy, e_done, e_pen, e_clk, e_sout;
      @(posedge clk);
      #1;
      c++;
      k   = c - FG;
      r_g = (k >= 0) ? (k % P) : -1;
      if (r_g == 1) cur_exp = model_frame(disp_num, point, le, (((c - 1) / BD) % 2) == 1);
      e_busy = (r_g >= 0) && (r_g <= SH + 1);
      e_done = (r_g == SH + 1);
      e_pen  = (c >= FG + SH + 1);
      e_clk  = 1'b0;
      e_sout = 1'b1;
      if (r_g >= 1 && r_g <= SH) begin
         s      = r_g - 1;
         e_clk  = (s % (2 * CD)) >= CD;
         e_sout = cur_exp[63 - s / (2 * CD)];
      end
      check("outs", {58'h0, busy, frame_done, seg_pen, seg_clrn, seg_clk, seg_sout},
            {58'h0, e_busy, e_done, e_pen, 1'b1, e_clk, e_sout});
      if (seg_clk && !prev_clk) begin
         cap = {cap[62:0], seg_sout};
         cap_n++;
      end
      prev_clk = seg_clk;
      if (frame_done) begin
         check("bit_count", 64'(cap_n), 64'd64);
         check("frame", cap, cur_exp);
         if (frame_idx < 4) check("known_frame", cap, known[frame_idx]);
         frame_idx++;
         cap_n = 0;
      end
   endtask

   task automatic check_reset_outs(input string tag);
      check(tag, {58'h0, busy, frame_done, seg_pen, seg_clrn, seg_clk, seg_sout}, 64'h1);
   endtask

   initial begin
      logic did_reset;
      seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      known   = '{64'hC0F9A4B0999282F8, 64'hC0F9A4B099928278,
                  64'h40F9A4B0999282F8, 64'h8E8E8E8E8E8E8E8E};
      tab_num = '{32'h01234567, 32'h01234567, 32'h01234567, 32'hFFFFFFFF,
                  32'h01234567, 32'h01234567, 32'h01234567};
      tab_pt  = '{8'h00, 8'h01, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00};
      tab_le  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 8'h80, 8'h80};
      did_reset = 1'b0;
      rst      = 1'b0;
      disp_num = tab_num[0];
      point    = tab_pt[0];
      le       = tab_le[0];
      c        = 0;
      repeat (3) begin
         @(negedge clk);
         check_reset_outs("reset_hold");
      end
      rst = 1'b1;
      #1;
      check_reset_outs("reset_release");

      for (int i = 0; i < 20000 && frame_idx < 18; i++) begin
         step();
         // Next frame's inputs are applied mid-SHIFT so they must not disturb the current frame
         if (r_g == 10) begin
            if (frame_idx + 1 < 7) begin
               disp_num = tab_num[frame_idx + 1];
               point    = tab_pt[frame_idx + 1];
               le       = tab_le[frame_idx + 1];
            end else begin
               disp_num = $urandom;
               point    = 8'($urandom);
               le       = 8'($urandom);
            end
         end else if (frame_idx >= 7 && $urandom_range(0, 63) == 0) begin
            disp_num = $urandom;
            point    = 8'($urandom);
            le       = 8'($urandom);
         end
         if (!did_reset && frame_idx == 12 && r_g == 1 + 30 * 2 * CD) begin
            did_reset = 1'b1;
            rst = 1'b0;
            #1;
            check_reset_outs("reset_mid_async");
            repeat (3) begin
               @(posedge clk);
               #1;
               check_reset_outs("reset_mid_hold");
            end
            @(negedge clk);
            rst = 1'b1;
            c = 0;
            cap_n = 0;
            prev_clk = 1'b0;
            check_reset_outs("reset_mid_release");
         end
      end
      check("frames_seen", 64'(frame_idx >= 18), 64'd1);
      check("reset_exercised", 64'(did_reset), 64'd1);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/seg_serial_drv.md
# seg_serial_drv

Serial eight-digit seven-segment driver at the display end of the 8-channel 32-bit display multiplexer. It consumes the selected 32-bit display number, 8-bit decimal-point mask and 8-bit blink mask, and decodes each nibble to a segment byte. It applies point and blink, then shifts the 64-bit frame out continuously to the board's cascaded segment shift registers. Frames repeat indefinitely, so input changes appear on the display within one frame period.

## Interface
- CLK_DIV, 2, system cycles per seg_clk half-period (≥1)
- FRAME_GAP, 16, idle cycles between frames (≥1)
- BLINK_DIV, 25000000, system cycles per blink-phase toggle (≥1)

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- Disp_num  in  32  hex value; digit i = Disp_num[4i+3:4i]
- point  in  8  point[i]=1 lights digit i decimal point
- LE  in  8  LE[i]=1 makes digit i blink
- seg_clk  out  1  shift clock to segment shift registers
- seg_sout  out  1  serial segment data
- seg_pen  out  1  display output enable
- seg_clrn  out  1  shift-register clear, active-low
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse when a frame completes

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - Gap counter counts FRAME_GAP cycles, then goes to LOAD.
  - IDLE is also the state after reset.
- LOAD (1 cycle):
  - Registers the 64-bit frame built from Disp_num, point, LE and the current blink_phase.
  - seg_sout takes frame[63].
  - Goes to SHIFT.
- SHIFT:
  - For each of 64 bits, seg_clk is low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - seg_sout is stable across the whole bit.
  - On the edge that ends the high phase, the register shifts left, seg_sout takes the next bit and seg_clk returns low.
  - After bit 64 the FSM goes to DONE.
- DONE (1 cycle):
  - frame_done=1.
  - seg_pen is set to 1 and stays 1 until reset.
  - Goes to IDLE.
- Frame layout:
  - Digit 7 byte first, digit 0 byte last; each byte MSB first.
  - Byte = {dp_n, g, f, e, d, c, b, a}, all active-low; dp_n = ~point[i].
- Hex decode (gfedcba, active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
- Blink:
  - A free-running counter toggles blink_phase every BLINK_DIV cycles.
  - If LE[i]=1 and blink_phase=1 at LOAD, byte i = FF (fully blanked, point included).
- Inputs are sampled only in LOAD. Changes during SHIFT, DONE or IDLE take effect in the next frame.
- If blink_phase toggles on the same edge as LOAD, the frame uses the pre-toggle value.
- busy = 1 in LOAD, SHIFT and DONE; 0 in IDLE.

## Timing
- Reset values (asserted and immediately after release):
  - seg_clk=0, seg_sout=1, seg_pen=0, busy=0, frame_done=0.
  - seg_clrn=0 while rst=0; seg_clrn=1 from the first edge after release.
  - blink_phase=0; state=IDLE with the gap counter cleared.
- First LOAD occurs FRAME_GAP cycles after reset release.
- Frame period = 1 + 128·CLK_DIV + 1 + FRAME_GAP cycles; 274 at defaults.
- frame_done asserts 1 + 128·CLK_DIV cycles after the LOAD cycle.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset asserted mid-frame:
  - All state returns to reset values immediately.
  - seg_pen drops to 0; the partial frame is abandoned.
  - The first post-reset frame is a complete frame.
- Counter widths: bit counter 7 bits (0..64); divider, gap and blink counters ≥ clog2 of their parameter; all wrap-free by construction.

## Test plan
- Disp_num=01234567, point=00, LE=00, CLK_DIV=1 -> a bench shift model on rising seg_clk captures C0 F9 A4 B0 99 92 82 F8; frame_done 129 cycles after LOAD; seg_pen rises at the first DONE.
- Same data with point=01 -> last byte 78, others unchanged. Then point=80 -> first byte 40.
- LE=80, BLINK_DIV=300, CLK_DIV=1, FRAME_GAP=16 -> first byte alternates C0/FF between frames per blink_phase; other bytes constant.
- Change Disp_num to FFFFFFFF during SHIFT -> current frame still shows 01234567; next frame shows 8E ×8.
- Pull rst low at bit 30 of a frame -> the next edge shows seg_clk=0, seg_sout=1, seg_pen=0, busy=0; after release, first LOAD at FRAME_GAP cycles and a full 64-bit frame.
- CLK_DIV=3 -> each seg_clk high and low phase lasts exactly 3 cycles; seg_sout never changes while seg_clk=1.
